// File: rtl/timer_pkg.sv
// ============================================================================
//  timer_pkg
//  Shared constants and state encoding for the MM:SS countdown timer.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package timer_pkg;

   localparam int DIGIT_W = 4;

   localparam logic [DIGIT_W-1:0] BCD_MAX      = 4'd9;
   localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;

   localparam logic [2:0] ENC_IDLE    = 3'd0;
   localparam logic [2:0] ENC_ENTRY   = 3'd1;
   localparam logic [2:0] ENC_RUNNING = 3'd2;
   localparam logic [2:0] ENC_PAUSED  = 3'd3;
   localparam logic [2:0] ENC_DONE    = 3'd4;

   typedef enum logic [2:0] {
      IDLE    = ENC_IDLE,
      ENTRY   = ENC_ENTRY,
      RUNNING = ENC_RUNNING,
      PAUSED  = ENC_PAUSED,
      DONE    = ENC_DONE
   } state_t;

endpackage

`default_nettype wire

// File: rtl/bcd_down_digit.sv
// ============================================================================
//  bcd_down_digit
//  One down-counting digit with parallel load; wraps to wrap_val with borrow.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_down_digit #(
   parameter int W = 4
) (
   input  logic         clock,
   input  logic         clear,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   input  logic [W-1:0] wrap_val,
   output logic [W-1:0] q,
   output logic         borrow_out
);

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = load_val;
      end else if (dec) begin
         q_d = (q_q == '0) ? wrap_val : q_q - 1'b1;
      end
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q          = q_q;
   assign borrow_out = dec & (q_q == '0);

endmodule

`default_nettype wire

// File: rtl/countdown_timer_mmss.sv
// ============================================================================
//  countdown_timer_mmss
//  Keypad-entered MM:SS cook timer: cook FSM, entry shift mux, zero detect.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module countdown_timer_mmss #(
   parameter int DIGIT_W         = timer_pkg::DIGIT_W,
   parameter int SEC_TENS_RELOAD = 5
) (
   input  logic               clock,
   input  logic               clear,
   input  logic               tick_1hz,
   input  logic               key_valid,
   input  logic [3:0]         key_code,
   input  logic               start,
   input  logic               stop,
   input  logic               door_closed,
   output logic [DIGIT_W-1:0] min_tens,
   output logic [DIGIT_W-1:0] min_ones,
   output logic [DIGIT_W-1:0] sec_tens,
   output logic [DIGIT_W-1:0] sec_ones,
   output logic               mag_on,
   output logic               done
);

   import timer_pkg::*;

   state_t state_q, state_d;
   logic   mag_q, done_q;

   // Digit index 0 = sec_ones ... 3 = min_tens
   logic [DIGIT_W-1:0] w_dig    [4];
   logic [3:0]         w_dec_in;
   logic [3:0]         w_borrow;
   logic               w_load;
   logic               w_shift;
   logic               w_dec;
   logic               w_zero;
   logic               w_last;
   logic               w_key_ok;
   logic               w_can_run;
   logic               w_unused_borrow;

   assign w_zero    = (w_dig[3] == '0) && (w_dig[2] == '0) &&
                      (w_dig[1] == '0) && (w_dig[0] == '0);
   // 00:01 is the only time whose decrement lands on 00:00
   assign w_last    = (w_dig[3] == '0) && (w_dig[2] == '0) &&
                      (w_dig[1] == '0) && (w_dig[0] == DIGIT_W'(1));
   assign w_key_ok  = key_valid && (key_code <= 4'd9);
   assign w_can_run = start && door_closed && !w_zero;

   always_comb begin
      state_d = state_q;
      w_load  = 1'b0;
      w_shift = 1'b0;
      w_dec   = 1'b0;
      unique case (state_q)
         IDLE, ENTRY: begin
            if (stop && state_q == ENTRY) begin
               w_load  = 1'b1;
               state_d = IDLE;
            end else if (w_can_run && state_q == ENTRY) begin
               state_d = RUNNING;
            end else if (w_key_ok) begin
               w_load  = 1'b1;
               w_shift = 1'b1;
               state_d = ENTRY;
            end
         end
         RUNNING: begin
            if (stop || !door_closed) begin
               state_d = PAUSED;
            end else if (tick_1hz && !w_zero) begin
               w_dec = 1'b1;
               if (w_last) begin
                  state_d = DONE;
               end
            end
         end
         PAUSED: begin
            if (stop) begin
               w_load  = 1'b1;
               state_d = IDLE;
            end else if (w_can_run) begin
               state_d = RUNNING;
            end
         end
         DONE: begin
            if (key_valid || start || stop) begin
               w_load  = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            w_load  = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_q <= IDLE;
         mag_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mag_q   <= (state_d == RUNNING);
         done_q  <= (state_d == DONE);
      end
   end

   generate
      for (genvar i = 0; i < 4; i++) begin : g_digit
         logic [DIGIT_W-1:0] w_load_val;
         logic [DIGIT_W-1:0] w_wrap_val;

         if (i == 0) begin : g_first
            assign w_dec_in[i] = w_dec;
            assign w_load_val  = w_shift ? DIGIT_W'(key_code) : '0;
         end else begin : g_chain
            assign w_dec_in[i] = w_borrow[i-1];
            assign w_load_val  = w_shift ? w_dig[i-1] : '0;
         end

         assign w_wrap_val = (i == 1) ? DIGIT_W'(SEC_TENS_RELOAD) : DIGIT_W'(BCD_MAX);

         bcd_down_digit #(
            .W (DIGIT_W)
         ) u_digit (
            .clock      (clock),
            .clear      (clear),
            .load       (w_load),
            .load_val   (w_load_val),
            .dec        (w_dec_in[i]),
            .wrap_val   (w_wrap_val),
            .q          (w_dig[i]),
            .borrow_out (w_borrow[i])
         );
      end
   endgenerate

   // Never set: decrement is blocked at 00:00
   assign w_unused_borrow = w_borrow[3];

   assign sec_ones = w_dig[0];
   assign sec_tens = w_dig[1];
   assign min_ones = w_dig[2];
   assign min_tens = w_dig[3];
   assign mag_on   = mag_q;
   assign done     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_countdown_timer_mmss.sv
// ============================================================================
//  tb_countdown_timer_mmss
//  Directed vector table plus hand sequences for the MM:SS countdown timer.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_countdown_timer_mmss;

   logic       clock = 1'b0;
   logic       clear;
   logic       tick_1hz;
   logic       key_valid;
   logic [3:0] key_code;
   logic       start;
   logic       stop;
   logic       door_closed;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic       mag_on;
   logic       done;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        kv;
      logic [3:0]  code;
      logic        st;
      logic        sp;
      logic        door;
      logic        tick;
      logic [15:0] t;
      logic        mag;
      logic        dn;
   } vec_t;

   vec_t vecs[$];

   countdown_timer_mmss #(
      .DIGIT_W         (4),
      .SEC_TENS_RELOAD (5)
   ) dut (
      .clock       (clock),
      .clear       (clear),
      .tick_1hz    (tick_1hz),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .start       (start),
      .stop        (stop),
      .door_closed (door_closed),
      .min_tens    (min_tens),
      .min_ones    (min_ones),
      .sec_tens    (sec_tens),
      .sec_ones    (sec_ones),
      .mag_on      (mag_on),
      .done        (done)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [15:0] t, input logic mag, input logic dn);
      logic [17:0] got, exp;
      got = {min_tens, min_ones, sec_tens, sec_ones, mag_on, done};
      exp = {t, mag, dn};
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got time=%h mag=%b done=%b, expected time=%h mag=%b done=%b",
                  name, got[17:2], got[1], got[0], t, mag, dn);
      end
   endtask

   task automatic add(input logic kv, input logic [3:0] code, input logic st, input logic sp,
                      input logic door, input logic tick, input logic [15:0] t,
                      input logic mag, input logic dn);
      vec_t v;
      v.kv = kv; v.code = code; v.st = st; v.sp = sp; v.door = door; v.tick = tick;
      v.t = t; v.mag = mag; v.dn = dn;
      vecs.push_back(v);
   endtask

   task automatic step(input logic kv, input logic [3:0] code, input logic st, input logic sp,
                       input logic door, input logic tick);
      key_valid   = kv;
      key_code    = code;
      start       = st;
      stop        = sp;
      door_closed = door;
      tick_1hz    = tick;
      @(posedge clock);
      #1;
   endtask

   task automatic key(input logic [3:0] code);
      step(1'b1, code, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      //  kv code st sp door tick  time      mag dn
      add(1, 1,   0, 0, 1,   0,    16'h0001, 0,  0);
      add(1, 2,   0, 0, 1,   0,    16'h0012, 0,  0);
      add(1, 3,   0, 0, 1,   0,    16'h0123, 0,  0);
      add(1, 0,   0, 0, 1,   0,    16'h1230, 0,  0);
      add(0, 0,   1, 0, 1,   1,    16'h1230, 1,  0);   // tick on start edge ignored
      add(0, 0,   0, 0, 1,   1,    16'h1229, 1,  0);
      add(0, 0,   0, 0, 1,   1,    16'h1228, 1,  0);
      add(0, 0,   0, 0, 1,   1,    16'h1227, 1,  0);
      add(0, 0,   0, 0, 1,   1,    16'h1226, 1,  0);
      add(0, 0,   0, 0, 1,   1,    16'h1225, 1,  0);
      add(0, 0,   0, 1, 1,   0,    16'h1225, 0,  0);   // pause
      add(0, 0,   0, 1, 1,   0,    16'h0000, 0,  0);   // back to idle
      add(1, 12,  0, 0, 1,   0,    16'h0000, 0,  0);   // invalid key
      add(0, 0,   1, 0, 1,   0,    16'h0000, 0,  0);   // start at 00:00
      add(1, 1,   0, 0, 1,   0,    16'h0001, 0,  0);
      add(1, 0,   0, 0, 1,   0,    16'h0010, 0,  0);
      add(1, 0,   0, 0, 1,   0,    16'h0100, 0,  0);
      add(1, 0,   0, 0, 1,   0,    16'h1000, 0,  0);
      add(0, 0,   1, 0, 1,   0,    16'h1000, 1,  0);
      add(0, 0,   0, 0, 1,   1,    16'h0959, 1,  0);   // full borrow chain
      add(0, 0,   0, 1, 1,   0,    16'h0959, 0,  0);
      add(0, 0,   0, 1, 1,   0,    16'h0000, 0,  0);
      add(1, 3,   0, 0, 1,   0,    16'h0003, 0,  0);
      add(1, 0,   0, 0, 1,   0,    16'h0030, 0,  0);
      add(0, 0,   1, 0, 1,   0,    16'h0030, 1,  0);
      add(0, 0,   0, 0, 0,   1,    16'h0030, 0,  0);   // door beats tick
      add(0, 0,   1, 0, 1,   0,    16'h0030, 1,  0);
      add(0, 0,   0, 1, 1,   0,    16'h0030, 0,  0);
      add(0, 0,   0, 1, 1,   0,    16'h0000, 0,  0);
      add(1, 4,   0, 0, 1,   0,    16'h0004, 0,  0);
      add(0, 0,   1, 0, 0,   0,    16'h0004, 0,  0);   // start with door open
      add(0, 0,   0, 1, 1,   0,    16'h0000, 0,  0);
      add(1, 5,   0, 0, 1,   0,    16'h0005, 0,  0);
      add(0, 0,   1, 1, 1,   0,    16'h0000, 0,  0);   // stop beats start
      add(1, 2,   0, 0, 1,   0,    16'h0002, 0,  0);
      add(0, 0,   1, 0, 1,   0,    16'h0002, 1,  0);
      add(0, 0,   0, 0, 1,   1,    16'h0001, 1,  0);
      add(0, 0,   0, 0, 1,   1,    16'h0000, 0,  1);   // reaches DONE
      add(0, 0,   0, 0, 1,   1,    16'h0000, 0,  1);   // no underflow
      add(1, 7,   0, 0, 1,   0,    16'h0000, 0,  0);   // key leaves DONE

      clear = 1'b1;
      key_valid = 1'b0; key_code = 4'd0; start = 1'b0; stop = 1'b0;
      door_closed = 1'b1; tick_1hz = 1'b0;
      @(posedge clock);
      #1;
      check("reset", 16'h0000, 1'b0, 1'b0);
      clear = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].kv, vecs[i].code, vecs[i].st, vecs[i].sp, vecs[i].door, vecs[i].tick);
         check($sformatf("vec%0d", i), vecs[i].t, vecs[i].mag, vecs[i].dn);
      end

      // Fifth digit drops the oldest one
      key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
      check("fifth_digit", 16'h2345, 1'b0, 1'b0);
      step(0, 0, 0, 1, 1, 0);
      check("fifth_stop", 16'h0000, 1'b0, 1'b0);

      // 00:99 runs with sec_tens above 5
      key(4'd9); key(4'd9);
      step(0, 0, 1, 0, 1, 0);
      check("s99_start", 16'h0099, 1'b1, 1'b0);
      for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 1, 1);
      check("s99_9ticks", 16'h0090, 1'b1, 1'b0);
      step(0, 0, 0, 0, 1, 1);
      check("s99_10ticks", 16'h0089, 1'b1, 1'b0);
      for (int i = 0; i < 30; i++) step(0, 0, 0, 0, 1, 1);
      check("s99_40ticks", 16'h0059, 1'b1, 1'b0);
      step(0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 1, 1, 0);
      check("s99_stop", 16'h0000, 1'b0, 1'b0);

      // Asynchronous clear while running at 03:27
      key(4'd3); key(4'd2); key(4'd7);
      step(0, 0, 1, 0, 1, 0);
      check("clr_running", 16'h0327, 1'b1, 1'b0);
      #2;
      clear = 1'b1;
      #1;
      check("clr_async", 16'h0000, 1'b0, 1'b0);
      #3;
      clear = 1'b0;
      step(0, 0, 0, 0, 1, 1);
      check("clr_after", 16'h0000, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
